// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Owns PC and IR, arbitrates the single memory port, and drives registered datapath controls.
module multicycle_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [2:0]  alu_sel,
    output logic [1:0]  imm_op,
    output logic        alu_src_imm,
    output logic [4:0]  wb_reg,
    output logic        wb_sel,
    output logic        reg_we,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_ALU = 3'd0,
        K_IMM = 3'd1,
        K_LW  = 3'd2,
        K_SW  = 3'd3,
        K_J   = 3'd4,
        K_BAD = 3'd5
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] alu_sel;
        logic [1:0] imm_op;
        logic       src_imm;
        logic [4:0] wb_reg;
    } dec_t;

    // Instruction classification; undecodable encodings fall back to K_BAD with idle controls.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.kind    = K_BAD;
        d.alu_sel = 3'b000;
        d.imm_op  = 2'b11;
        d.src_imm = 1'b0;
        d.wb_reg  = 5'd0;
        case (instr[31:26])
            6'd0: begin
                d.kind   = K_ALU;
                d.wb_reg = instr[15:11];
                case (instr[5:0])
                    6'd32:   d.alu_sel = 3'b000;
                    6'd24:   d.alu_sel = 3'b001;
                    6'd36:   d.alu_sel = 3'b010;
                    6'd37:   d.alu_sel = 3'b011;
                    6'd39:   d.alu_sel = 3'b101;
                    6'd0:    d.alu_sel = 3'b110;
                    6'd2:    d.alu_sel = 3'b111;
                    default: begin
                        d.kind   = K_BAD;
                        d.wb_reg = 5'd0;
                    end
                endcase
            end
            6'd8:  begin d.kind = K_IMM; d.imm_op = 2'b00; d.src_imm = 1'b1; d.wb_reg = instr[20:16]; end
            6'd36: begin d.kind = K_IMM; d.imm_op = 2'b01; d.src_imm = 1'b1; d.wb_reg = instr[20:16]; end
            6'd13: begin d.kind = K_IMM; d.imm_op = 2'b10; d.src_imm = 1'b1; d.wb_reg = instr[20:16]; end
            6'd35: begin d.kind = K_LW;  d.imm_op = 2'b00; d.src_imm = 1'b1; d.wb_reg = instr[20:16]; end
            6'd43: begin d.kind = K_SW;  d.imm_op = 2'b00; d.src_imm = 1'b1; end
            6'd2:  d.kind = K_J;
            default: d.kind = K_BAD;
        endcase
        return d;
    endfunction

    state_t        r_state;
    state_t        w_next;
    kind_t         r_kind;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_pc;
    logic [31:0]   r_ir;
    logic          r_mem_req;
    logic          r_mem_we;
    logic          r_mem_sel_data;
    logic [2:0]    r_alu_sel;
    logic [1:0]    r_imm_op;
    logic          r_alu_src_imm;
    logic [4:0]    r_wb_reg;
    logic          r_wb_sel;
    logic          r_reg_we;
    logic          r_halted;
    logic          r_illegal;
    logic          r_bus_err;
    dec_t          w_dec;
    logic          w_accept;
    logic          w_wait;
    logic          w_timeout;

    assign w_dec     = decode(mem_rdata);
    assign w_accept  = r_mem_req & mem_ready;
    assign w_wait    = r_mem_req & ~mem_ready;
    assign w_timeout = w_wait & (r_cnt == CW'(MEM_TIMEOUT - 1));

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout)     w_next = S_HALT;
                else if (w_accept) w_next = S_DECODE;
                else               w_next = S_FETCH;
            end
            S_DECODE: begin
                case (r_kind)
                    K_J:     w_next = S_FETCH;
                    K_BAD:   w_next = S_HALT;
                    default: w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if ((r_kind == K_LW) || (r_kind == K_SW)) w_next = S_MEM;
                else                                      w_next = S_WB;
            end
            S_MEM: begin
                if (w_timeout)             w_next = S_HALT;
                else if (!w_accept)        w_next = S_MEM;
                else if (r_kind == K_SW)   w_next = S_FETCH;
                else                       w_next = S_WB;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    // State, PC/IR, timeout counter and registered controls for the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_FETCH;
            r_kind         <= K_BAD;
            r_cnt          <= '0;
            r_pc           <= RESET_PC;
            r_ir           <= 32'h0000_0000;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_sel_data <= 1'b0;
            r_alu_sel      <= 3'b000;
            r_imm_op       <= 2'b11;
            r_alu_src_imm  <= 1'b0;
            r_wb_reg       <= 5'd0;
            r_wb_sel       <= 1'b0;
            r_reg_we       <= 1'b0;
            r_halted       <= 1'b0;
            r_illegal      <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_mem_req      <= (w_next == S_FETCH) || (w_next == S_MEM);
            r_mem_we       <= (w_next == S_MEM) && (r_kind == K_SW);
            r_mem_sel_data <= (w_next == S_MEM);
            r_reg_we       <= (w_next == S_WB);
            r_wb_sel       <= (w_next == S_WB) && (r_kind == K_LW);
            r_halted       <= (w_next == S_HALT);
            // Decode is taken straight from the fetched word so controls are valid during DECODE.
            if ((r_state == S_FETCH) && (w_next == S_DECODE)) begin
                r_ir          <= mem_rdata;
                r_pc          <= r_pc + 32'd1;
                r_kind        <= w_dec.kind;
                r_alu_sel     <= w_dec.alu_sel;
                r_imm_op      <= w_dec.imm_op;
                r_alu_src_imm <= w_dec.src_imm;
                r_wb_reg      <= w_dec.wb_reg;
            end else if ((r_state == S_DECODE) && (r_kind == K_J)) begin
                r_pc <= {r_pc[31:26], r_ir[25:0]};
            end else begin
                r_pc <= r_pc;
            end
            if ((r_state == S_DECODE) && (r_kind == K_BAD)) r_illegal <= 1'b1;
            else                                            r_illegal <= r_illegal;
            if (w_timeout && ((r_state == S_FETCH) || (r_state == S_MEM))) r_bus_err <= 1'b1;
            else                                                          r_bus_err <= r_bus_err;
            if (w_next != r_state) r_cnt <= '0;
            else if (w_wait)       r_cnt <= r_cnt + CW'(1);
            else                   r_cnt <= r_cnt;
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_sel_data = r_mem_sel_data;
    assign pc           = r_pc;
    assign ir           = r_ir;
    assign alu_sel      = r_alu_sel;
    assign imm_op       = r_imm_op;
    assign alu_src_imm  = r_alu_src_imm;
    assign wb_reg       = r_wb_reg;
    assign wb_sel       = r_wb_sel;
    assign reg_we       = r_reg_we;
    assign halted       = r_halted;
    assign illegal      = r_illegal;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: a cycle-counting memory responder against an instruction-level model.
module tb_multicycle_controller;

    localparam int KA = 0, KI = 1, KL = 2, KS = 3, KJ = 4, KB = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_req, mem_we, mem_sel_data, wb_sel, reg_we, halted, illegal, bus_err, alu_src_imm;
    logic [31:0] pc, ir;
    logic [2:0]  alu_sel;
    logic [1:0]  imm_op;
    logic [4:0]  wb_reg;
    logic        j_mem_req, j_mem_we, j_mem_sel_data, j_wb_sel, j_reg_we, j_halted, j_illegal, j_bus_err, j_alu_src_imm;
    logic [31:0] j_pc, j_ir;
    logic [2:0]  j_alu_sel;
    logic [1:0]  j_imm_op;
    logic [4:0]  j_wb_reg;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_rwe = 0;
    logic [31:0] pc_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_controller #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc), .ir(ir), .alu_sel(alu_sel),
        .imm_op(imm_op), .alu_src_imm(alu_src_imm), .wb_reg(wb_reg), .wb_sel(wb_sel),
        .reg_we(reg_we), .halted(halted), .illegal(illegal), .bus_err(bus_err));

    multicycle_controller #(.RESET_PC(32'h0400_0005), .MEM_TIMEOUT(16)) u_dut_j (
        .clk(clk), .rst_n(rst_n), .mem_req(j_mem_req), .mem_we(j_mem_we), .mem_sel_data(j_mem_sel_data),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(j_pc), .ir(j_ir), .alu_sel(j_alu_sel),
        .imm_op(j_imm_op), .alu_src_imm(j_alu_src_imm), .wb_reg(j_wb_reg), .wb_sel(j_wb_sel),
        .reg_we(j_reg_we), .halted(j_halted), .illegal(j_illegal), .bus_err(j_bus_err));

    function automatic int kind_of(input logic [31:0] in);
        case (in[31:26])
            6'd0: begin
                case (in[5:0])
                    6'd32, 6'd24, 6'd36, 6'd37, 6'd39, 6'd0, 6'd2: return KA;
                    default: return KB;
                endcase
            end
            6'd8, 6'd36, 6'd13: return KI;
            6'd35: return KL;
            6'd43: return KS;
            6'd2:  return KJ;
            default: return KB;
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input logic [5:0] fn);
        case (fn)
            6'd32: return 3'b000;
            6'd24: return 3'b001;
            6'd36: return 3'b010;
            6'd37: return 3'b011;
            6'd39: return 3'b101;
            6'd0:  return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [5:0] op);
        case (op)
            6'd36:   return 2'b01;
            6'd13:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fn [0:6];
        logic [5:0]  ops [0:5];
        logic [31:0] r;
        int          c;
        fn  = '{6'd32, 6'd24, 6'd36, 6'd37, 6'd39, 6'd0, 6'd2};
        ops = '{6'd8, 6'd36, 6'd13, 6'd35, 6'd43, 6'd2};
        r = $urandom;
        c = $urandom_range(0, 6);
        if (c == 0) return {6'd0, r[25:6], fn[$urandom_range(0, 6)]};
        return {ops[c - 1], r[25:0]};
    endfunction

    task automatic wait_fetch();
        int g = 0;
        while (!(mem_req && !mem_sel_data) && g < 8) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!(mem_req && !mem_sel_data)) begin
            errors++;
            $display("FAIL wait_fetch: mem_req=%0b sel=%0b, required fetch request", mem_req, mem_sel_data);
        end
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pc_m = 32'h0;
        wait_fetch();
    endtask

    // One legal instruction from fetch request to the next fetch request, fw/mw wait states.
    task automatic exec_instr(input logic [31:0] instr, input int fw, input int mw);
        int k, lat, rwe, rwe_lat, mcyc, wecyc, explat;
        k = kind_of(instr);
        rwe = 0; rwe_lat = 0; mcyc = 0; wecyc = 0;
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        mem_rdata = instr;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        pc_m = pc_m + 32'd1;
        checks++; if (pc !== pc_m) begin errors++; $display("FAIL pc_inc: got %h want %h", pc, pc_m); end
        checks++; if (ir !== instr) begin errors++; $display("FAIL ir_load: got %h want %h", ir, instr); end
        if (k == KA) begin
            checks++; if (alu_sel !== exp_alu(instr[5:0])) begin errors++; $display("FAIL alu_sel: got %b want %b ir=%h", alu_sel, exp_alu(instr[5:0]), instr); end
            checks++; if (wb_reg !== instr[15:11]) begin errors++; $display("FAIL wb_reg_rd: got %0d want %0d", wb_reg, instr[15:11]); end
            checks++; if (alu_src_imm !== 1'b0) begin errors++; $display("FAIL alu_src_r: got %b want 0", alu_src_imm); end
        end
        if (k == KI || k == KL || k == KS) begin
            checks++; if (imm_op !== exp_imm(instr[31:26])) begin errors++; $display("FAIL imm_op: got %b want %b ir=%h", imm_op, exp_imm(instr[31:26]), instr); end
            checks++; if (alu_src_imm !== 1'b1) begin errors++; $display("FAIL alu_src_i: got %b want 1", alu_src_imm); end
        end
        if (k == KI || k == KL) begin
            checks++; if (wb_reg !== instr[20:16]) begin errors++; $display("FAIL wb_reg_rt: got %0d want %0d", wb_reg, instr[20:16]); end
        end
        if (k == KJ) pc_m = {pc_m[31:26], instr[25:0]};
        lat = 1;
        while (!(mem_req && !mem_sel_data) && !halted && lat < 40) begin
            if (reg_we) begin
                rwe++;
                rwe_lat = lat;
                last_rwe = cyc;
                checks++; if (wb_sel !== (k == KL)) begin errors++; $display("FAIL wb_sel: got %b want %b", wb_sel, (k == KL)); end
            end
            if (mem_req && mem_sel_data) begin
                mcyc++;
                if (mem_we) wecyc++;
                mem_ready = (mcyc > mw);
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        mem_ready = 1'b0;
        explat = (k == KJ) ? 2 : (k == KL) ? 5 + mw : (k == KS) ? 4 + mw : 4;
        checks++; if (lat !== explat) begin errors++; $display("FAIL latency: got %0d want %0d ir=%h", lat, explat, instr); end
        checks++; if (rwe !== ((k == KA || k == KI || k == KL) ? 1 : 0)) begin errors++; $display("FAIL reg_we_count: got %0d ir=%h", rwe, instr); end
        if (rwe == 1) begin
            checks++; if (rwe_lat !== explat - 1) begin errors++; $display("FAIL reg_we_time: got %0d want %0d", rwe_lat, explat - 1); end
        end
        checks++; if (mcyc !== ((k == KL || k == KS) ? mw + 1 : 0)) begin errors++; $display("FAIL mem_cycles: got %0d mw=%0d ir=%h", mcyc, mw, instr); end
        checks++; if (wecyc !== ((k == KS) ? mw + 1 : 0)) begin errors++; $display("FAIL mem_we_cycles: got %0d ir=%h", wecyc, instr); end
        checks++; if (pc !== pc_m || halted !== 1'b0) begin errors++; $display("FAIL next_pc: got %h halted=%b want %h", pc, halted, pc_m); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (pc !== 32'h0 || ir !== 32'h0 || j_pc !== 32'h0400_0005) begin errors++; $display("FAIL reset_pc_ir: pc=%h ir=%h jpc=%h", pc, ir, j_pc); end
        checks++; if ({mem_req, mem_we, reg_we, halted, illegal, bus_err} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b want 000000", {mem_req, mem_we, reg_we, halted, illegal, bus_err}); end
        checks++; if ({mem_sel_data, alu_sel, imm_op, alu_src_imm, wb_sel, wb_reg} !== {1'b0, 3'b000, 2'b11, 1'b0, 1'b0, 5'd0}) begin errors++; $display("FAIL reset_selects: imm_op=%b alu_sel=%b wb_reg=%0d", imm_op, alu_sel, wb_reg); end
        @(negedge clk);
        rst_n = 1'b1;
        pc_m = 32'h0;
        wait_fetch();
    endtask

    task automatic test_jump_illegal();
        exec_instr(32'h0800_0010, 0, 0);
        checks++; if (j_pc !== 32'h0400_0010) begin errors++; $display("FAIL jump_region: got %h want 04000010", j_pc); end
        mem_ready = 1'b1;
        mem_rdata = 32'hFC00_0000;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({halted, illegal, bus_err, mem_req} !== 4'b1100) begin errors++; $display("FAIL illegal_halt: halted/illegal/bus_err/req=%b want 1100", {halted, illegal, bus_err, mem_req}); end
        for (int i = 0; i < 6; i++) begin
            mem_ready = $urandom_range(0, 1);
            @(negedge clk);
            checks++; if (mem_req !== 1'b0 || reg_we !== 1'b0 || pc !== 32'h11 || halted !== 1'b1) begin errors++; $display("FAIL halt_frozen: req=%b we=%b pc=%h", mem_req, reg_we, pc); end
        end
        do_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'h0022_183F;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({halted, illegal} !== 2'b11) begin errors++; $display("FAIL bad_funct: halted/illegal=%b want 11", {halted, illegal}); end
    endtask

    task automatic test_alu_ops();
        int t1;
        do_reset();
        exec_instr(32'h2001_0005, 0, 0);
        exec_instr(32'h0022_1820, 0, 0);
        t1 = last_rwe;
        exec_instr(32'h0022_1824, 0, 0);
        checks++; if (last_rwe - t1 !== 4) begin errors++; $display("FAIL back_to_back: reg_we gap %0d want 4", last_rwe - t1); end
    endtask

    task automatic test_mem_ops();
        exec_instr(32'h8C24_0008, 0, 2);
        exec_instr(32'hAC24_0004, 1, 0);
        exec_instr(32'hAC24_0004, 0, 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) exec_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        mem_ready = 1'b0;
        while (mem_req && !halted && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", n); end
        checks++; if ({halted, bus_err, illegal, mem_req} !== 4'b1100 || pc !== 32'h0) begin errors++; $display("FAIL bus_err_halt: flags=%b pc=%h", {halted, bus_err, illegal, mem_req}, pc); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'hAC24_0004;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({mem_req, mem_sel_data, mem_we} !== 3'b111) begin errors++; $display("FAIL sw_in_mem: req/sel/we=%b want 111", {mem_req, mem_sel_data, mem_we}); end
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || mem_we !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL reset_mid_mem: pc=%h we=%b req=%b", pc, mem_we, mem_req); end
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_we !== 1'b0 || mem_sel_data !== 1'b0) begin errors++; $display("FAIL post_reset_we: we=%b sel=%b", mem_we, mem_sel_data); end
        end
        mem_ready = 1'b0;
        checks++; if (pc !== 32'h0000_0001 || ir !== 32'hAC24_0004) begin errors++; $display("FAIL post_reset_fetch: pc=%h ir=%h", pc, ir); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_jump_illegal();
        test_alu_ops();
        test_mem_ops();
        test_random();
        test_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
